sparse_core_sequencer: RTL and testbench

//  Control FSM that sequences one sparse_core through a job.
//  - Loads a 4-row 2:4-sparse weight tile from weight memory into the core's w_rows.
//  - Streams cfg_num_vec activation vectors from activation memory, pulsing core_en once per vector.
//  - Captures the four psum outputs and returns them on a valid/ready result port.
//  - Sits between the memory subsystem / host control and sparse_core.

---
 rtl/sparse_core_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_sparse_core_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_core_sequencer.sv
// Sequences one sparse_core job: weight tile load, per-vector fetch/compute, psum result port.
// Vector period is 3 + CORE_LAT cycles; while res_ready is low OUT holds its result and nothing new is fetched.
module sparse_core_sequencer #(
   parameter int NUM_PE   = 4,
   parameter int ADDR_W   = 10,
   parameter int CORE_LAT = 2,
   parameter int CNT_W    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      cfg_w_base,
   input  logic [ADDR_W-1:0]      cfg_a_base,
   input  logic [CNT_W-1:0]       cfg_num_vec,
   output logic                   busy,
   output logic                   done,
   output logic                   err_idx,
   output logic                   wmem_rd,
   output logic [ADDR_W-1:0]      wmem_addr,
   input  logic [7:0]             wmem_val,
   input  logic [1:0]             wmem_idx,
   output logic                   amem_rd,
   output logic [ADDR_W-1:0]      amem_addr,
   input  logic [31:0]            amem_data,
   output logic                   core_en,
   output logic [NUM_PE*20-1:0]   core_w_rows,
   output logic [31:0]            core_act_vec,
   input  logic [NUM_PE*20-1:0]   core_psum,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [NUM_PE*20-1:0]   res_data,
   output logic [CNT_W-1:0]       res_idx
);

   localparam int PKT_W = 20;
   localparam int NW    = 2 * NUM_PE;
   localparam int K_W   = $clog2(NW + 1);
   localparam int LAT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_W, S_CHECK, S_FETCH, S_DRIVE, S_WAIT, S_OUT, S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       w_base_q, w_base_d;
   logic [ADDR_W-1:0]       a_base_q, a_base_d;
   logic [CNT_W-1:0]        num_vec_q, num_vec_d;
   logic [K_W-1:0]          k_q, k_d;
   logic [CNT_W-1:0]        n_q, n_d;
   logic [LAT_W-1:0]        lat_q, lat_d;
   logic [NUM_PE*PKT_W-1:0] w_rows_q, w_rows_d;
   logic [31:0]             act_q, act_d;
   logic                    err_q, err_d;
   logic                    res_valid_q, res_valid_d;
   logic [NUM_PE*PKT_W-1:0] res_data_q, res_data_d;
   logic [CNT_W-1:0]        res_idx_q, res_idx_d;

   logic [K_W-1:0]          cap_k;
   int                      cap_row;
   logic [CNT_W-1:0]        n_inc;

   always_comb begin
      state_d     = state_q;
      w_base_d    = w_base_q;
      a_base_d    = a_base_q;
      num_vec_d   = num_vec_q;
      k_d         = k_q;
      n_d         = n_q;
      lat_d       = lat_q;
      w_rows_d    = w_rows_q;
      act_d       = act_q;
      err_d       = err_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_idx_d   = res_idx_q;
      busy        = 1'b0;
      done        = 1'b0;
      wmem_rd     = 1'b0;
      wmem_addr   = '0;
      amem_rd     = 1'b0;
      amem_addr   = '0;
      core_en     = 1'b0;
      core_act_vec = act_q;
      cap_k       = k_q - K_W'(1);
      cap_row     = int'(cap_k >> 1);
      n_inc       = n_q + CNT_W'(1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               w_base_d  = cfg_w_base;
               a_base_d  = cfg_a_base;
               num_vec_d = cfg_num_vec;
               err_d     = 1'b0;
               k_d       = '0;
               state_d   = S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            busy = 1'b1;
            if (k_q < K_W'(NW)) begin
               wmem_rd   = 1'b1;
               wmem_addr = w_base_q + ADDR_W'(k_q);
            end
            // Read data lags the strobe by one cycle, so k_q captures read k_q-1.
            if (k_q != '0) begin
               if (cap_k[0] == 1'b0) begin
                  w_rows_d[cap_row*PKT_W +: 8]      = wmem_val;
                  w_rows_d[cap_row*PKT_W + 8 +: 2]  = wmem_idx;
               end else begin
                  w_rows_d[cap_row*PKT_W + 10 +: 8] = wmem_val;
                  w_rows_d[cap_row*PKT_W + 18 +: 2] = wmem_idx;
               end
            end
            k_d = k_q + K_W'(1);
            if (k_q == K_W'(NW)) state_d = S_CHECK;
         end
         S_CHECK: begin
            busy = 1'b1;
            for (int r = 0; r < NUM_PE; r++) begin
               if (w_rows_q[r*PKT_W + 8 +: 2] >= w_rows_q[r*PKT_W + 18 +: 2]) err_d = 1'b1;
            end
            n_d     = '0;
            state_d = (num_vec_q == '0) ? S_DONE : S_FETCH;
         end
         S_FETCH: begin
            busy      = 1'b1;
            amem_rd   = 1'b1;
            amem_addr = a_base_q + ADDR_W'(n_q);
            state_d   = S_DRIVE;
         end
         S_DRIVE: begin
            // Bypass the fresh word so the core sees it on its enable edge.
            busy         = 1'b1;
            core_en      = 1'b1;
            core_act_vec = amem_data;
            act_d        = amem_data;
            lat_d        = '0;
            state_d      = S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            if (lat_q == LAT_W'(CORE_LAT - 1)) begin
               res_data_d  = core_psum;
               res_idx_d   = n_q;
               res_valid_d = 1'b1;
               state_d     = S_OUT;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         S_OUT: begin
            busy = 1'b1;
            if (res_ready) begin
               res_valid_d = 1'b0;
               n_d         = n_inc;
               state_d     = (n_inc == num_vec_q) ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         w_base_q    <= '0;
         a_base_q    <= '0;
         num_vec_q   <= '0;
         k_q         <= '0;
         n_q         <= '0;
         lat_q       <= '0;
         w_rows_q    <= '0;
         act_q       <= '0;
         err_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         w_base_q    <= w_base_d;
         a_base_q    <= a_base_d;
         num_vec_q   <= num_vec_d;
         k_q         <= k_d;
         n_q         <= n_d;
         lat_q       <= lat_d;
         w_rows_q    <= w_rows_d;
         act_q       <= act_d;
         err_q       <= err_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_idx_q   <= res_idx_d;
      end
   end

   assign err_idx     = err_q;
   assign core_w_rows = w_rows_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_idx     = res_idx_q;

endmodule

// File: tb/tb_sparse_core_sequencer.sv
// Bench for sparse_core_sequencer: memory and core models, scoreboarded result port.
module tb_sparse_core_sequencer;
   localparam int NUM_PE   = 4;
   localparam int ADDR_W   = 10;
   localparam int CORE_LAT = 2;
   localparam int CNT_W    = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [ADDR_W-1:0]    cfg_w_base = '0;
   logic [ADDR_W-1:0]    cfg_a_base = '0;
   logic [CNT_W-1:0]     cfg_num_vec = '0;
   logic                 busy, done, err_idx;
   logic                 wmem_rd, amem_rd, core_en;
   logic [ADDR_W-1:0]    wmem_addr, amem_addr;
   logic [7:0]           wmem_val = '0;
   logic [1:0]           wmem_idx = '0;
   logic [31:0]          amem_data = '0;
   logic [79:0]          core_w_rows;
   logic [31:0]          core_act_vec;
   logic [79:0]          core_psum;
   logic                 res_valid;
   logic                 res_ready = 1'b0;
   logic [79:0]          res_data;
   logic [CNT_W-1:0]     res_idx;

   sparse_core_sequencer #(
      .NUM_PE(NUM_PE), .ADDR_W(ADDR_W), .CORE_LAT(CORE_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_w_base(cfg_w_base), .cfg_a_base(cfg_a_base), .cfg_num_vec(cfg_num_vec),
      .busy(busy), .done(done), .err_idx(err_idx),
      .wmem_rd(wmem_rd), .wmem_addr(wmem_addr), .wmem_val(wmem_val), .wmem_idx(wmem_idx),
      .amem_rd(amem_rd), .amem_addr(amem_addr), .amem_data(amem_data),
      .core_en(core_en), .core_w_rows(core_w_rows), .core_act_vec(core_act_vec),
      .core_psum(core_psum),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx)
   );

   always #5 clk = ~clk;

   // Memories with one-cycle read latency.
   logic [7:0]  wv [1024];
   logic [1:0]  wi [1024];
   logic [31:0] am [1024];

   always @(posedge clk) begin
      if (wmem_rd) begin
         wmem_val <= wv[wmem_addr];
         wmem_idx <= wi[wmem_addr];
      end
      if (amem_rd) amem_data <= am[amem_addr];
   end

   // Non-accumulating 2:4 sparse core, CORE_LAT deep; zero unless enabled so mistimed sampling shows.
   function automatic logic [79:0] core_calc(input logic [79:0] w, input logic [31:0] a);
      logic [79:0] o;
      int v0, v1, i0, i1, l0, l1, s;
      o = '0;
      for (int r = 0; r < 4; r++) begin
         v0 = $signed(w[r*20 +: 8]);
         i0 = int'(w[r*20 + 8 +: 2]);
         v1 = $signed(w[r*20 + 10 +: 8]);
         i1 = int'(w[r*20 + 18 +: 2]);
         l0 = $signed(a[i0*8 +: 8]);
         l1 = $signed(a[i1*8 +: 8]);
         s  = v0 * l0 + v1 * l1;
         o[r*20 +: 20] = 20'(s);
      end
      return o;
   endfunction

   logic [79:0] cp0 = '0;
   logic [79:0] cp1 = '0;
   always @(posedge clk) begin
      cp0 <= core_en ? core_calc(core_w_rows, core_act_vec) : 80'd0;
      cp1 <= cp0;
   end
   assign core_psum = cp1;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_wrd = 0, n_ard = 0, n_en = 0, n_done = 0, done_cyc = 0;
   always @(negedge clk) begin
      if (wmem_rd) n_wrd++;
      if (amem_rd) n_ard++;
      if (core_en) n_en++;
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
   end

   int checks = 0;
   int errors = 0;
   logic [95:0] exp_q[$];
   int hs_cyc[$];
   int start_cyc = 0;

   task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   function automatic logic [79:0] pk(input int p0, input int p1, input int p2, input int p3);
      return {20'(p3), 20'(p2), 20'(p1), 20'(p0)};
   endfunction

   function automatic logic [31:0] aw(input int l0, input int l1, input int l2, input int l3);
      return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
   endfunction

   task automatic push_exp(input int idx, input logic [79:0] d);
      exp_q.push_back({16'(idx), d});
   endtask

   task automatic set_row(input int base, input int r, input int v0, input int i0,
                          input int v1, input int i1);
      wv[(base + 2*r) % 1024]     = 8'(v0);
      wi[(base + 2*r) % 1024]     = 2'(i0);
      wv[(base + 2*r + 1) % 1024] = 8'(v1);
      wi[(base + 2*r + 1) % 1024] = 2'(i1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int wb, input int ab, input int nv);
      cfg_w_base  = ADDR_W'(wb);
      cfg_a_base  = ADDR_W'(ab);
      cfg_num_vec = CNT_W'(nv);
      start       = 1'b1;
      start_cyc   = cyc;
      step();
      start       = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int maxc);
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (done) return;
      end
      checks++;
      errors++;
      $display("FAIL %s done not seen within %0d cycles", nm, maxc);
   endtask

   task automatic monitor();
      logic [95:0] e;
      forever begin
         @(negedge clk);
         if (res_valid && res_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL res_unexpected idx=%0d data=%0h want=none", res_idx, res_data);
            end else begin
               e = exp_q.pop_front();
               chk("res_data", {16'd0, res_data}, {16'd0, e[79:0]});
               chk("res_idx", {80'd0, res_idx}, {80'd0, e[95:80]});
            end
         end
      end
   endtask

   int w0, a0, e0, d0, ok, seen;

   initial begin
      fork
         monitor();
      join_none

      // Tile A at 0, tile B at 16 (row2 has idx_0 == idx_1).
      set_row(0, 0, 12, 0, 9, 1);
      set_row(0, 1, 16, 1, 8, 3);
      set_row(0, 2, -5, 0, -5, 2);
      set_row(0, 3, -19, 2, -17, 3);
      set_row(16, 0, 12, 0, 9, 1);
      set_row(16, 1, 16, 1, 8, 3);
      set_row(16, 2, -5, 1, -5, 1);
      set_row(16, 3, -19, 2, -17, 3);
      am[100]  = aw(10, 10, 10, 10);
      am[1022] = aw(1, 1, 1, 1);
      am[1023] = aw(2, 2, 2, 2);
      am[0]    = aw(3, 3, 3, 3);
      am[200]  = aw(1, 2, 3, 4);
      am[201]  = aw(-1, -2, -3, -4);
      am[400]  = aw(10, 10, 10, 10);
      am[500]  = aw(10, 10, 10, 10);
      am[501]  = aw(10, 10, 10, 10);

      repeat (3) step();
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_rows", core_w_rows, 0);
      chk("rst_strobes", {wmem_rd, amem_rd, core_en, err_idx}, 0);
      step();
      rst = 1'b0;
      step();

      // T1 basic job
      res_ready = 1'b1;
      w0 = n_wrd; a0 = n_ard; e0 = n_en; d0 = n_done;
      push_exp(0, pk(210, 240, -100, -360));
      start_job(0, 100, 1);
      wait_done("t1", 200);
      step();
      chk("t1_wmem_reads", n_wrd - w0, 8);
      chk("t1_amem_reads", n_ard - a0, 1);
      chk("t1_core_en", n_en - e0, 1);
      chk("t1_done_pulses", n_done - d0, 1);
      chk("t1_err_idx", err_idx, 0);
      chk("t1_busy_after", busy, 0);
      step();

      // T2 streaming with activation address wrap
      hs_cyc.delete();
      e0 = n_en; d0 = n_done;
      push_exp(0, pk(21, 24, -10, -36));
      push_exp(1, pk(42, 48, -20, -72));
      push_exp(2, pk(63, 72, -30, -108));
      start_job(0, 1022, 3);
      wait_done("t2", 300);
      step();
      chk("t2_handshakes", hs_cyc.size(), 3);
      if (hs_cyc.size() == 3) begin
         chk("t2_period0", hs_cyc[1] - hs_cyc[0], 3 + CORE_LAT);
         chk("t2_period1", hs_cyc[2] - hs_cyc[1], 3 + CORE_LAT);
      end
      chk("t2_core_en", n_en - e0, 3);
      chk("t2_done_pulses", n_done - d0, 1);
      step();

      // T3 backpressure, distinct lanes
      res_ready = 1'b0;
      a0 = n_ard; e0 = n_en;
      push_exp(0, pk(30, 64, -20, -125));
      push_exp(1, pk(-30, -64, 20, 125));
      start_job(0, 200, 2);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (res_valid) begin
            ok = 1;
            break;
         end
      end
      chk("t3_valid_seen", ok, 1);
      repeat (5) begin
         @(negedge clk);
         chk("t3_stall_valid", res_valid, 1);
         chk("t3_stall_data", res_data, pk(30, 64, -20, -125));
         chk("t3_stall_core_en", core_en, 0);
         chk("t3_stall_amem_rd", amem_rd, 0);
      end
      step();
      res_ready = 1'b1;
      wait_done("t3", 200);
      step();
      chk("t3_amem_reads", n_ard - a0, 2);
      chk("t3_core_en", n_en - e0, 2);
      step();

      // T4 empty job
      w0 = n_wrd; a0 = n_ard; e0 = n_en; d0 = n_done;
      start_job(0, 300, 0);
      wait_done("t4", 100);
      step();
      chk("t4_wmem_reads", n_wrd - w0, 8);
      chk("t4_amem_reads", n_ard - a0, 0);
      chk("t4_core_en", n_en - e0, 0);
      chk("t4_done_latency", done_cyc - start_cyc, 11);
      chk("t4_done_pulses", n_done - d0, 1);
      step();

      // T5 bad index still yields results
      push_exp(0, pk(210, 240, -100, -360));
      start_job(16, 400, 1);
      wait_done("t5", 200);
      step();
      chk("t5_err_idx", err_idx, 1);
      step();

      // T6 start while busy ignored, reset in WAIT of vector 1
      hs_cyc.delete();
      w0 = n_wrd;
      push_exp(0, pk(210, 240, -100, -360));
      start_job(0, 500, 2);
      @(negedge clk);
      chk("t6_err_cleared", err_idx, 0);
      step();
      step();
      cfg_w_base  = ADDR_W'(16);
      cfg_num_vec = CNT_W'(0);
      start       = 1'b1;
      step();
      start       = 1'b0;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (core_en) begin
            seen++;
            if (seen == 2) break;
         end
      end
      chk("t6_second_core_en", seen, 2);
      step();
      chk("t6_wmem_reads", n_wrd - w0, 8);
      chk("t6_busy_in_wait", busy, 1);
      d0 = n_done;
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_valid", res_valid, 0);
      chk("t6_rst_data", {res_data, res_idx}, 0);
      chk("t6_rst_rows", core_w_rows, 0);
      chk("t6_rst_act", core_act_vec, 0);
      chk("t6_rst_strobes", {wmem_rd, amem_rd, core_en, done}, 0);
      repeat (20) step();
      chk("t6_no_done", n_done - d0, 0);
      chk("t6_idle_busy", busy, 0);
      chk("t6_handshakes", hs_cyc.size(), 1);
      chk("queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
